// File: rtl/sprite_store_bank.sv
// Per-scanline sprite store: the OAM scanner fills slots in priority order, and the pixel pipe looks them up by X.
// The optional overflow counter is enabled by defining SPRITE_STORE_OVF_CNT_EN; otherwise ovf_cnt is tied to zero.
module sprite_store_bank #(
  parameter int SLOTS  = 10,
  parameter int IDX_W  = 6,
  parameter int LINE_W = 4,
  parameter int X_W    = 8,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              line_start,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [IDX_W-1:0]  st_idx,
  input  logic [LINE_W-1:0] st_line,
  input  logic [X_W-1:0]    st_x,
  input  logic [X_W-1:0]    cur_x,
  output logic              match_valid,
  output logic [SLOT_W-1:0] match_slot,
  output logic [IDX_W-1:0]  match_idx,
  output logic [LINE_W-1:0] match_line,
  input  logic              match_ack,
  output logic [SLOT_W:0]   count,
  output logic              full,
  output logic [7:0]        ovf_cnt
);

  logic [SLOTS-1:0]  valid;
  logic [IDX_W-1:0]  idx_mem  [SLOTS];
  logic [LINE_W-1:0] line_mem [SLOTS];
  logic [X_W-1:0]    x_mem    [SLOTS];

  logic              wr_fire;
  logic              ack_fire;
  logic              hit;
  logic [SLOT_W-1:0] hit_slot;
  logic [IDX_W-1:0]  hit_idx;
  logic [LINE_W-1:0] hit_line;

  assign full     = (count == (SLOT_W+1)'(SLOTS));
  assign st_ready = !full;
  assign wr_fire  = st_valid && !full && !line_start;
  assign ack_fire = match_ack && match_valid;

  // The slot being acked is masked so the next same-X sprite is presented on the very next cycle.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    hit_idx  = '0;
    hit_line = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (valid[i] && !(ack_fire && match_slot == SLOT_W'(i)) && x_mem[i] == cur_x) begin
        hit      = 1'b1;
        hit_slot = SLOT_W'(i);
        hit_idx  = idx_mem[i];
        hit_line = line_mem[i];
      end
    end
  end

  // Slot payload carries no reset; only the valid bits decide what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (wr_fire && count == (SLOT_W+1)'(i)) begin
        idx_mem[i]  <= st_idx;
        line_mem[i] <= st_line;
        x_mem[i]    <= st_x;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid       <= '0;
      count       <= '0;
      match_valid <= 1'b0;
      match_slot  <= '0;
      match_idx   <= '0;
      match_line  <= '0;
    end else if (line_start) begin
      valid       <= '0;
      count       <= '0;
      match_valid <= 1'b0;
      match_slot  <= '0;
      match_idx   <= '0;
      match_line  <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (wr_fire && count == (SLOT_W+1)'(i)) begin
          valid[i] <= 1'b1;
        end else if (ack_fire && match_slot == SLOT_W'(i)) begin
          valid[i] <= 1'b0;
        end
      end
      if (wr_fire) begin
        count <= count + 1'b1;
      end
      match_valid <= hit;
      match_slot  <= hit_slot;
      match_idx   <= hit_idx;
      match_line  <= hit_line;
    end
  end

`ifdef SPRITE_STORE_OVF_CNT_EN
  logic [7:0] ovf_q;

  // Survives line_start so software can read a running total of dropped hits.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ovf_q <= '0;
    end else if (st_valid && full && !line_start && ovf_q != 8'hFF) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule
